// File: rtl/ws_mac_pkg.sv
// ws_mac_pkg: shared default widths, weight-state enum and signed round-shift helper for the MAC PE
package ws_mac_pkg;
  localparam int DATA_W_D = 8;
  localparam int WEIGHT_W_D = 8;
  localparam int ACC_W_D = 20;
  localparam int OUT_W_D = 8;
  localparam int SHIFT_D = 8;
  typedef enum logic {NO_W, HAVE_W} w_state_t;
  function automatic logic signed [63:0] round_shift(input logic signed [63:0] v, input int unsigned sh);
    return (v + (64'sd1 <<< (sh - 1))) >>> sh;
  endfunction
endpackage

// File: rtl/ws_mac_if.sv
// ws_mac_if: weight, input-stream, forwarding and output-stream signals of one MAC PE
interface ws_mac_if import ws_mac_pkg::*; #(
  parameter int DATA_W = DATA_W_D,
  parameter int WEIGHT_W = WEIGHT_W_D,
  parameter int ACC_W = ACC_W_D,
  parameter int OUT_W = OUT_W_D
);
  logic w_load;
  logic w_clear;
  logic w_loaded;
  logic signed [WEIGHT_W-1:0] w_data;
  logic in_valid;
  logic in_ready;
  logic signed [DATA_W-1:0] x_data;
  logic signed [ACC_W-1:0] psum_in;
  logic signed [DATA_W-1:0] x_fwd;
  logic x_fwd_valid;
  logic out_valid;
  logic out_ready;
  logic signed [ACC_W-1:0] psum_out;
  logic signed [OUT_W-1:0] q_out;
  modport master (
    output w_load, w_data, w_clear, in_valid, x_data, psum_in, out_ready,
    input w_loaded, in_ready, x_fwd, x_fwd_valid, out_valid, psum_out, q_out
  );
  modport slave (
    input w_load, w_data, w_clear, in_valid, x_data, psum_in, out_ready,
    output w_loaded, in_ready, x_fwd, x_fwd_valid, out_valid, psum_out, q_out
  );
endinterface

// File: rtl/ws_mac_quant.sv
// ws_mac_quant: round-half-up arithmetic shift of a partial sum to OUT_W bits; WS_MAC_SAT_EN saturates instead of truncating
module ws_mac_quant import ws_mac_pkg::*; #(
  parameter int ACC_W = ACC_W_D,
  parameter int OUT_W = OUT_W_D,
  parameter int SHIFT = SHIFT_D
) (
  input  logic signed [ACC_W-1:0] psum,
  output logic signed [OUT_W-1:0] q
);
`ifdef WS_MAC_SAT_EN
  localparam logic signed [63:0] Q_MAX = (64'sd1 <<< (OUT_W - 1)) - 64'sd1;
  localparam logic signed [63:0] Q_MIN = -(64'sd1 <<< (OUT_W - 1));
  logic signed [63:0] r;
  // clamp the rounded value into the signed OUT_W range
  always_comb begin
    r = round_shift(64'(psum), SHIFT);
    q = r > Q_MAX ? OUT_W'(Q_MAX) : r < Q_MIN ? OUT_W'(Q_MIN) : OUT_W'(r);
  end
`else
  assign q = OUT_W'(round_shift(64'(psum), SHIFT));
`endif
endmodule

// File: rtl/ws_mac_pe.sv
// ws_mac_pe: weight-stationary signed MAC PE, 2-stage valid/ready pipeline; WS_MAC_SAT_EN enables saturation
module ws_mac_pe import ws_mac_pkg::*; #(
  parameter int DATA_W = DATA_W_D,
  parameter int WEIGHT_W = WEIGHT_W_D,
  parameter int ACC_W = ACC_W_D,
  parameter int OUT_W = OUT_W_D,
  parameter int SHIFT = SHIFT_D
) (
  input logic clk,
  input logic reset_n,
  ws_mac_if.slave bus
);
  localparam int PW = DATA_W + WEIGHT_W;
  w_state_t w_st, w_nx;
  logic signed [WEIGHT_W-1:0] weight;
  logic s1_v;
  logic signed [PW-1:0] s1_prod;
  logic signed [ACC_W-1:0] s1_psum;
  logic signed [ACC_W-1:0] sum;
  logic signed [OUT_W-1:0] q_next;
  logic s2_adv;
  logic fire;
  assign w_nx = bus.w_load ? HAVE_W : bus.w_clear ? NO_W : w_st;
  assign s2_adv = !bus.out_valid | bus.out_ready;
  assign bus.in_ready = bus.w_loaded & (!s1_v | s2_adv);
  assign fire = bus.in_valid & bus.in_ready;
`ifdef WS_MAC_SAT_EN
  logic signed [ACC_W:0] sum_x;
  assign sum_x = (ACC_W + 1)'(s1_prod) + (ACC_W + 1)'(s1_psum);
  assign sum = sum_x[ACC_W] != sum_x[ACC_W-1] ? {sum_x[ACC_W], {(ACC_W - 1){!sum_x[ACC_W]}}} : sum_x[ACC_W-1:0];
`else
  assign sum = ACC_W'(s1_prod) + s1_psum;
`endif
  ws_mac_quant #(.ACC_W(ACC_W), .OUT_W(OUT_W), .SHIFT(SHIFT)) u_quant (.psum(sum), .q(q_next));
  // weight state: load wins over clear, the new weight is visible from the next cycle
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      w_st <= NO_W;
      weight <= '0;
      bus.w_loaded <= 1'b0;
    end else begin
      w_st <= w_nx;
      weight <= bus.w_load ? bus.w_data : weight;
      bus.w_loaded <= w_nx == HAVE_W;
    end
  // stage 1: capture product with the weight held before this edge, plus the upstream psum
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      s1_v <= 1'b0;
      s1_prod <= '0;
      s1_psum <= '0;
    end else if (!s1_v | s2_adv) begin
      s1_v <= fire;
      if (fire) begin
        s1_prod <= PW'(bus.x_data) * PW'(weight);
        s1_psum <= bus.psum_in;
      end
    end
  // stage 2: accumulate and quantise, held while the result waits for out_ready
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      bus.out_valid <= 1'b0;
      bus.psum_out <= '0;
      bus.q_out <= '0;
    end else if (s2_adv) begin
      bus.out_valid <= s1_v;
      if (s1_v) begin
        bus.psum_out <= sum;
        bus.q_out <= q_next;
      end
    end
  // forward each accepted activation to the neighbour as a one-cycle pulse
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      bus.x_fwd_valid <= 1'b0;
      bus.x_fwd <= '0;
    end else begin
      bus.x_fwd_valid <= fire;
      if (fire) bus.x_fwd <= bus.x_data;
    end
endmodule

// File: tb/tb_ws_mac_pe.sv
// tb_ws_mac_pe: randomized and directed checks of ws_mac_pe against an arithmetic reference model
module tb_ws_mac_pe;
  localparam int DW = 8;
  localparam int WW = 8;
  localparam int AW = 20;
  localparam int OW = 8;
  localparam int SH = 8;
  logic clk = 1'b0;
  logic reset_n = 1'b1;
  always #5 clk = ~clk;
  ws_mac_if #(.DATA_W(DW), .WEIGHT_W(WW), .ACC_W(AW), .OUT_W(OW)) bus();
  ws_mac_pe #(.DATA_W(DW), .WEIGHT_W(WW), .ACC_W(AW), .OUT_W(OW), .SHIFT(SH)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus.slave)
  );
  int passed = 0;
  int total = 0;
  longint exp_q[$];
  longint mw = 0;
  bit have_w = 0;
  bit stall_chk = 0;
  longint held_p, held_q;
  bit fwd_chk = 0;
  longint fwd_x;
  bit last_fire, last_ready;
  int outs = 0;

  task automatic check(string tag, longint got, longint exp);
    total++;
    if (got == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  function automatic longint wrap(longint v, int w);
    longint m = longint'(1) << w;
    longint r = v % m;
    if (r < 0) r += m;
    return (r >= m / 2) ? r - m : r;
  endfunction

  function automatic longint clamp(longint v, int w);
    longint hi = (longint'(1) << (w - 1)) - 1;
    return v > hi ? hi : (v < -hi - 1 ? -hi - 1 : v);
  endfunction

  function automatic longint model_psum(longint p);
`ifdef WS_MAC_SAT_EN
    return clamp(p, AW);
`else
    return wrap(p, AW);
`endif
  endfunction

  function automatic longint model_q(longint p);
    longint r = (p + (longint'(1) << (SH - 1))) >>> SH;
`ifdef WS_MAC_SAT_EN
    return clamp(r, OW);
`else
    return wrap(r, OW);
`endif
  endfunction

  task automatic step(bit v, longint x, longint ps, bit ld = 0, longint wd = 0, bit clr = 0, bit ordy = 1);
    longint p;
    bus.in_valid = v;
    bus.x_data = DW'(x);
    bus.psum_in = AW'(ps);
    bus.w_load = ld;
    bus.w_data = WW'(wd);
    bus.w_clear = clr;
    bus.out_ready = ordy;
    #1;
    check("fwd_valid", longint'(bus.x_fwd_valid), longint'(fwd_chk));
    if (fwd_chk) check("fwd_x", longint'(bus.x_fwd), fwd_x);
    check("w_loaded", longint'(bus.w_loaded), longint'(have_w));
    if (!have_w) check("ready_no_w", longint'(bus.in_ready), 0);
    if (stall_chk) begin
      check("stall_valid", longint'(bus.out_valid), 1);
      check("stall_psum", longint'(bus.psum_out), held_p);
      check("stall_q", longint'(bus.q_out), held_q);
    end
    last_ready = bus.in_ready;
    last_fire = v & bus.in_ready;
    if (bus.out_valid && ordy) begin
      outs++;
      if (exp_q.size() == 0) check("spurious_out", 1, 0);
      else begin
        p = exp_q.pop_front();
        check("psum_out", longint'(bus.psum_out), p);
        check("q_out", longint'(bus.q_out), model_q(p));
      end
    end
    stall_chk = bus.out_valid & !ordy;
    held_p = longint'(bus.psum_out);
    held_q = longint'(bus.q_out);
    if (last_fire) exp_q.push_back(model_psum(ps + x * mw));
    fwd_chk = last_fire;
    fwd_x = x;
    if (ld) begin
      mw = wd;
      have_w = 1;
    end else if (clr) have_w = 0;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drain();
    for (int i = 0; i < 30 && (exp_q.size() > 0 || bus.out_valid); i++) step(0, 0, 0);
    check("drain_empty", longint'(exp_q.size()), 0);
  endtask

  task automatic check_zero(string tag);
    check({tag, "_w_loaded"}, longint'(bus.w_loaded), 0);
    check({tag, "_in_ready"}, longint'(bus.in_ready), 0);
    check({tag, "_out_valid"}, longint'(bus.out_valid), 0);
    check({tag, "_fwd_valid"}, longint'(bus.x_fwd_valid), 0);
    check({tag, "_x_fwd"}, longint'(bus.x_fwd), 0);
    check({tag, "_psum"}, longint'(bus.psum_out), 0);
    check({tag, "_q"}, longint'(bus.q_out), 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    longint sat_p, sat_q;
    int sent;
    bus.in_valid = 0;
    bus.x_data = '0;
    bus.psum_in = '0;
    bus.w_load = 0;
    bus.w_data = '0;
    bus.w_clear = 0;
    bus.out_ready = 1;
    reset_n = 1'b0;
    #1;
    check_zero("reset");
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (3) step(1, 5, 10);
    check("no_w_out_valid", longint'(bus.out_valid), 0);
    check("no_w_queue", longint'(exp_q.size()), 0);
    step(0, 0, 0, 1, 3);
    step(1, 5, 10);
    check("fire_basic", longint'(last_fire), 1);
    check("lat_cycle1", longint'(bus.out_valid), 0);
    step(0, 0, 0);
    check("lat_cycle2", longint'(bus.out_valid), 1);
    check("basic_psum", longint'(bus.psum_out), 25);
    check("basic_q", longint'(bus.q_out), 0);
    step(1, 5, 1000);
    step(0, 0, 0);
    check("p1000_psum", longint'(bus.psum_out), 1015);
    check("p1000_q", longint'(bus.q_out), 4);
    drain();
    outs = 0;
    sent = 0;
    for (int c = 0; c < 40 && (sent < 8 || exp_q.size() > 0); c++) begin
      step(sent < 8, sent * 7 - 20, sent * 100, 0, 0, 0, !(c >= 3 && c < 6));
      if (c == 4) check("stall_in_ready", longint'(last_ready), 0);
      sent += int'(last_fire);
    end
    drain();
    check("b2b_count", longint'(outs), 8);
    step(1, 4, 0, 1, 2);
    step(1, 4, 0);
    check("old_w_psum", longint'(bus.psum_out), 12);
    step(0, 0, 0);
    check("new_w_psum", longint'(bus.psum_out), 8);
    drain();
    step(0, 0, 0, 1, -128);
    step(1, -128, 0);
    step(0, 0, 0);
    check("edge_psum", longint'(bus.psum_out), 16384);
    check("edge_q", longint'(bus.q_out), 64);
    drain();
    step(0, 0, 0, 1, 127);
    step(1, 127, (1 << 19) - 1);
    step(0, 0, 0);
`ifdef WS_MAC_SAT_EN
    sat_p = (1 << 19) - 1;
    sat_q = 127;
`else
    sat_p = -508160;
    sat_q = 63;
`endif
    check("ovf_psum", longint'(bus.psum_out), sat_p);
    check("ovf_q", longint'(bus.q_out), sat_q);
    drain();
    step(1, 1, 1, 1, 1, 1);
    check("load_wins", longint'(bus.w_loaded), 1);
    step(1, 2, 2, 0, 0, 1);
    step(1, 3, 3);
    check("clear_blocks", longint'(last_fire), 0);
    drain();
    step(0, 0, 0, 1, 3);
    for (int i = 0; i < 300; i++) begin
      longint x = longint'($urandom_range(0, 255)) - 128;
      longint ps = ($urandom_range(0, 7) == 0) ? (($urandom_range(0, 1) == 1) ? (1 << 19) - 1 : -(1 << 19))
                                               : longint'($urandom_range(0, (1 << 20) - 1)) - (1 << 19);
      bit ld = $urandom_range(0, 19) == 0;
      bit clr = $urandom_range(0, 29) == 0;
      step($urandom_range(0, 3) != 0, x, ps, ld, longint'($urandom_range(0, 255)) - 128, clr, $urandom_range(0, 9) < 7);
    end
    drain();
    step(0, 0, 0, 1, 9);
    step(1, 10, 20);
    step(1, 11, 21);
    #2;
    reset_n = 1'b0;
    #1;
    check_zero("async_reset");
    exp_q.delete();
    have_w = 0;
    fwd_chk = 0;
    stall_chk = 0;
    @(negedge clk);
    reset_n = 1'b1;
    step(1, 5, 5);
    check("post_reset_queue", longint'(exp_q.size()), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/ws_mac_pe.md
Name: ws_mac_pe

Overview:
Parametrised, signed weight-stationary MAC processing element. It is the building block for a systolic row or column in the accelerator datapath.
- Holds one weight, streams activations with valid/ready, and adds an incoming partial sum.
- Emits a full-width partial sum for chaining, plus a rounded, quantised result.
- Forwards each accepted activation to the neighbouring PE.

Parameters:
DATA_W, 8, activation width (signed)
WEIGHT_W, 8, weight width (signed)
ACC_W, 20, partial-sum width (signed); must be >= DATA_W+WEIGHT_W+1
OUT_W, 8, quantised output width (signed)
SHIFT, 8, right-shift applied for quantisation; 1..ACC_W-1

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
w_load  in  1  weight load strobe
w_data  in  WEIGHT_W  weight value
w_loaded  out  1  a weight has been loaded since reset/clear
w_clear  in  1  invalidate held weight
in_valid  in  1  x_data and psum_in are valid
in_ready  out  1  PE accepts input
x_data  in  DATA_W  activation
psum_in  in  ACC_W  upstream partial sum
x_fwd  out  DATA_W  registered copy of last accepted activation
x_fwd_valid  out  1  one-cycle pulse, per accepted activation
out_valid  out  1  result valid
out_ready  in  1  downstream accepts result
psum_out  out  ACC_W  psum_in + x_data*weight
q_out  out  OUT_W  quantised psum_out

Behaviour:
Reset: only clk/reset_n are fixed; reset is asynchronous, active-low. While reset_n is low, all registers and outputs are 0: weight, w_loaded, pipeline valids, x_fwd, x_fwd_valid, psum_out, q_out.
Weight state (2 states: NO_W, HAVE_W):
- w_load moves to HAVE_W and captures w_data.
- w_clear moves to NO_W.
- w_load and w_clear together: w_load wins.
- w_loaded=1 in HAVE_W.
Input handshake:
- in_ready = w_loaded & (stage-1 empty | stage-1 advancing).
- Input fire = in_valid & in_ready.
- In NO_W, in_ready=0.
Weight/sample ordering: a sample firing in the same cycle as w_load uses the OLD weight; the new weight applies from the next cycle. Samples already in the pipeline always complete with the weight they captured.
Pipeline, 2 stages, latency 2 cycles from fire to out_valid with no backpressure:
- S1 registers the signed product x_data*weight (DATA_W+WEIGHT_W bits) and psum_in.
- S2 registers psum_out = sign-extended product + psum_in, wrapping modulo 2^ACC_W, and q_out.
Backpressure:
- out_valid & !out_ready holds S2 stable.
- S1 advances only if S2 is empty or firing.
- Full throughput of 1 sample/cycle when out_ready=1.
- out_valid must not drop until accepted.
Quantisation: r = (psum_out + 2^(SHIFT-1)) >>> SHIFT, an arithmetic shift (round half up). q_out = r[OUT_W-1:0], truncated.
Forwarding: on fire, x_fwd <= x_data and x_fwd_valid=1 for exactly one cycle. x_fwd is independent of out_ready.
w_clear mid-stream: in-flight samples still drain and emit normally; only new input is blocked.

Optional Feature:
Macro WS_MAC_SAT_EN.
- Defined: q_out saturates r to [-2^(OUT_W-1), 2^(OUT_W-1)-1]. psum_out saturates to the ACC_W signed range instead of wrapping.
- Undefined: both wrap, as described above.

Decomposition:
- Shared package ws_mac_pkg holds the default width constants, the weight-state enum (NO_W, HAVE_W), and a signed round-shift function.
- Sub-module ws_mac_quant (round, shift, optional saturate) is combinational and instantiated in S2.

Test Plan:
- Reset then in_valid=1 before any w_load -> in_ready=0, out_valid stays 0, w_loaded=0.
- Defaults; w_load w=3; fire x=5, psum_in=10 -> out_valid exactly 2 cycles later, psum_out=25, q_out=0. Repeat with psum_in=1000: 1015 -> q_out=4.
- Back-to-back 8 samples with out_ready=1 -> 8 consecutive out_valid cycles in order. Hold out_ready=0 for 3 cycles mid-stream -> in_ready drops, outputs stable, no loss or duplication.
- w_load w=2 in the same cycle as firing x=4 (old w=3) -> that result is 12; the next sample x=4 gives 8.
- Signed edge: x=-128, w=-128, psum_in=0 -> psum_out=16384, q_out=64. Check: (16384+128)>>>8 = 64.
- WS_MAC_SAT_EN overflow: x=127, w=127, psum_in=2^19-1 -> psum_out=2^19-1 and q_out=127 when defined; wrapped values when undefined. Also assert reset_n low mid-stream -> all outputs 0 immediately, asynchronously.
